// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if
//   Operand/result bundle for the bit-serial subtractor.
//   slave  : the subtractor side (takes start/operands, drives results)
//   master : the requester side (drives start/operands, watches results)
//   Signals:
//     start_i       start request, sampled on the rising clock edge
//     a_i, b_i      minuend / subtrahend, WIDTH bits
//     bin_i         borrow-in
//     d_o           registered difference a - b - bin (mod 2^WIDTH)
//     bout_o        registered borrow-out
//     ovf_o         registered two's-complement overflow
//     zero_o        registered "difference is zero"
//     busy_o        high while bits are being processed
//     done_o        one-cycle pulse when a new result is available
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             bin_i;
    logic [WIDTH-1:0] d_o;
    logic             bout_o;
    logic             ovf_o;
    logic             zero_o;
    logic             busy_o;
    logic             done_o;

    modport slave (
        input  start_i, a_i, b_i, bin_i,
        output d_o, bout_o, ovf_o, zero_o, busy_o, done_o
    );

    modport master (
        output start_i, a_i, b_i, bin_i,
        input  d_o, bout_o, ovf_o, zero_o, busy_o, done_o
    );
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first.
//   A start accepted in IDLE or DONE captures the operands; RUN then takes
//   exactly WIDTH edges, and the result flags are loaded on the last one.
//   Ports:
//     clk_i   rising-edge clock
//     rstn_i  synchronous active-low reset (wins over start)
//     bus     serial_subtractor_if.slave: start/operands in, results out

// One-bit full subtractor slice. Purely combinational; the borrow chain is
// closed through the borrow register in the parent.
module serial_subtractor_bit (
    input  logic a,
    input  logic b,
    input  logic br,
    output logic diff,
    output logic br_next
);
    assign diff    = a ^ b ^ br;
    assign br_next = (~a & b) | (~(a ^ b) & br);
endmodule

module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    serial_subtractor_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    // a_sr doubles as the result collector: each RUN edge consumes a_sr[0]
    // and shifts the new difference bit in at the top, so after WIDTH edges
    // it holds the full difference.
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             br;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] d_q;
    logic             bout_q;
    logic             ovf_q;
    logic             zero_q;

    logic             diff;
    logic             br_next;
    logic             last_bit;
    logic [WIDTH-1:0] result;

    serial_subtractor_bit u_bit (
        .a       (a_sr[0]),
        .b       (b_sr[0]),
        .br      (br),
        .diff    (diff),
        .br_next (br_next)
    );

    assign last_bit = (cnt == CW'(WIDTH - 1));
    assign result   = {diff, a_sr[WIDTH-1:1]};

    // State register
    always_ff @(posedge clk_i) begin
        if (!rstn_i) state <= IDLE;
        else         state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start_i) state_next = RUN;
            RUN:     if (last_bit)    state_next = DONE;
            DONE:    state_next = bus.start_i ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand capture, bit-serial processing, result load
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            a_sr   <= '0;
            b_sr   <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            d_q    <= '0;
            bout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start_i) begin
                        a_sr <= bus.a_i;
                        b_sr <= bus.b_i;
                        br   <= bus.bin_i;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    // Counter saturates at WIDTH; the FSM leaves RUN on the
                    // same edge, so processing never runs past the MSB.
                    if (cnt != CW'(WIDTH)) begin
                        a_sr <= result;
                        b_sr <= b_sr >> 1;
                        br   <= br_next;
                        cnt  <= cnt + CW'(1);
                        if (last_bit) begin
                            d_q    <= result;
                            bout_q <= br_next;
                            // br here is the borrow into the MSB
                            ovf_q  <= br ^ br_next;
                            zero_q <= (result == '0);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.d_o    = d_q;
    assign bus.bout_o = bout_q;
    assign bus.ovf_o  = ovf_q;
    assign bus.zero_o = zero_q;
    assign bus.busy_o = (state == RUN);
    assign bus.done_o = (state == DONE);
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
//   Directed bench for serial_subtractor at WIDTH=8. Inputs change on the
//   falling edge; outputs are sampled on the falling edge.
module tb_serial_subtractor;
    localparam int WIDTH = 8;

    logic clk;
    logic rstn;
    int   errors = 0;
    int   checks = 0;
    int   n, nb;

    serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present operands with start for one edge, then drop start.
    // Returns at the falling edge right after acceptance.
    task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic bin);
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.a_i     = a;
        bus.b_i     = b;
        bus.bin_i   = bin;
        @(negedge clk);
        bus.start_i = 1'b0;
    endtask

    // Count falling edges until done_o is seen (bounded); nbusy counts
    // the sampled cycles with busy_o high.
    task automatic wait_done(output int cyc, output int nbusy);
        cyc   = 0;
        nbusy = 0;
        while (bus.done_o !== 1'b1 && cyc < 40) begin
            if (bus.busy_o === 1'b1) nbusy++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic check_result(input string tag, input logic [7:0] d, input logic bout,
                                input logic ovf, input logic zero);
        check({tag, ".d"},    32'(bus.d_o),    32'(d));
        check({tag, ".bout"}, 32'(bus.bout_o), 32'(bout));
        check({tag, ".ovf"},  32'(bus.ovf_o),  32'(ovf));
        check({tag, ".zero"}, 32'(bus.zero_o), 32'(zero));
        check({tag, ".busy"}, 32'(bus.busy_o), 32'd0);
    endtask

    initial begin
        rstn        = 1'b0;
        bus.start_i = 1'b0;
        bus.a_i     = '0;
        bus.b_i     = '0;
        bus.bin_i   = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst.d",    32'(bus.d_o),    32'd0);
        check("rst.bout", 32'(bus.bout_o), 32'd0);
        check("rst.ovf",  32'(bus.ovf_o),  32'd0);
        check("rst.zero", 32'(bus.zero_o), 32'd0);
        check("rst.busy", 32'(bus.busy_o), 32'd0);
        check("rst.done", 32'(bus.done_o), 32'd0);
        rstn = 1'b1;

        // 5 - 3: latency and busy length
        start_op(8'h05, 8'h03, 1'b0);
        check("op1.busy_after_accept", 32'(bus.busy_o), 32'd1);
        wait_done(n, nb);
        check("op1.latency", 32'(n), 32'd8);
        check("op1.busy_cycles", 32'(nb), 32'd8);
        check_result("op1", 8'h02, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("op1.done_single", 32'(bus.done_o), 32'd0);
        check("op1.d_held", 32'(bus.d_o), 32'h02);

        // 3 - 5: borrow out
        start_op(8'h03, 8'h05, 1'b0);
        wait_done(n, nb);
        check("op2.latency", 32'(n), 32'd8);
        check_result("op2", 8'hFE, 1'b1, 1'b0, 1'b0);

        // 0x80 - 1: signed overflow
        start_op(8'h80, 8'h01, 1'b0);
        check("op3.d_held_in_run", 32'(bus.d_o), 32'hFE);
        wait_done(n, nb);
        check_result("op3", 8'h7F, 1'b0, 1'b1, 1'b0);

        // 0x10 - 0x0F - 1: zero result
        start_op(8'h10, 8'h0F, 1'b1);
        wait_done(n, nb);
        check_result("op4", 8'h00, 1'b0, 1'b0, 1'b1);

        // start during RUN and operand changes after acceptance are ignored
        start_op(8'h05, 8'h03, 1'b0);
        repeat (2) @(negedge clk);
        bus.start_i = 1'b1;
        bus.a_i     = 8'hFF;
        bus.b_i     = 8'h00;
        bus.bin_i   = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        check("ign.d_held_in_run", 32'(bus.d_o), 32'h00);
        wait_done(n, nb);
        check("ign.remaining", 32'(n), 32'd5);
        check_result("ign", 8'h02, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("ign.no_restart", 32'(bus.busy_o), 32'd0);

        // Back-to-back: start held in the DONE cycle
        start_op(8'h03, 8'h05, 1'b0);
        wait_done(n, nb);
        check_result("b2b1", 8'hFE, 1'b1, 1'b0, 1'b0);
        bus.start_i = 1'b1;
        bus.a_i     = 8'h80;
        bus.b_i     = 8'h01;
        bus.bin_i   = 1'b0;
        @(negedge clk);
        bus.start_i = 1'b0;
        check("b2b.done_single", 32'(bus.done_o), 32'd0);
        check("b2b.busy", 32'(bus.busy_o), 32'd1);
        wait_done(n, nb);
        check("b2b.spacing", 32'(n + 1), 32'd9);
        check_result("b2b2", 8'h7F, 1'b0, 1'b1, 1'b0);

        // Reset mid-run aborts with no done
        start_op(8'h05, 8'h03, 1'b0);
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        check("mrst.d",    32'(bus.d_o),    32'd0);
        check("mrst.bout", 32'(bus.bout_o), 32'd0);
        check("mrst.ovf",  32'(bus.ovf_o),  32'd0);
        check("mrst.zero", 32'(bus.zero_o), 32'd0);
        check("mrst.busy", 32'(bus.busy_o), 32'd0);
        check("mrst.done", 32'(bus.done_o), 32'd0);
        // reset wins over start
        bus.start_i = 1'b1;
        @(negedge clk);
        check("mrst.prio_busy", 32'(bus.busy_o), 32'd0);
        check("mrst.prio_done", 32'(bus.done_o), 32'd0);
        bus.start_i = 1'b0;
        rstn = 1'b1;
        repeat (10) @(negedge clk);
        check("mrst.no_done", 32'(bus.done_o), 32'd0);

        // First start after reset: 0xFF - 0xFF - 1
        start_op(8'hFF, 8'hFF, 1'b1);
        wait_done(n, nb);
        check("post.latency", 32'(n), 32'd8);
        check_result("post", 8'hFF, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("post.idle", 32'(bus.done_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, 8, operand and result width in bits (legal range 2..32).
REQ-002 The block SHALL use one clock and a synchronous, active-low reset: clk_i input 1, rising-edge clock; rstn_i input 1, synchronous active-low reset.
REQ-003 start_i input 1: request to start one subtraction, sampled on the rising edge of clk_i.
REQ-004 a_i input WIDTH: minuend, sampled together with start_i.
REQ-005 b_i input WIDTH: subtrahend, sampled together with start_i.
REQ-006 bin_i input 1: borrow-in, sampled together with start_i.
REQ-007 d_o output WIDTH: registered difference a - b - bin, modulo 2^WIDTH.
REQ-008 bout_o output 1: registered borrow-out (1 when a < b + bin, unsigned).
REQ-009 ovf_o output 1: registered two's-complement overflow flag.
REQ-010 zero_o output 1: registered flag, 1 when d_o == 0.
REQ-011 busy_o output 1: high while a subtraction is in progress.
REQ-012 done_o output 1: one-cycle pulse marking a new valid result.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-014 In IDLE or DONE with start_i=1, the next edge SHALL capture a_i, b_i and bin_i into internal shift registers, load the borrow register with bin_i, clear the bit counter and enter RUN.
REQ-015 In RUN, each edge SHALL process one bit, LSB first, with no shared state across the bit slice: diff = a^b^br; br_next = (~a&b) | (~(a^b)&br).
REQ-016 RUN SHALL last exactly WIDTH edges; on the WIDTH-th edge the FSM SHALL enter DONE and load d_o, bout_o, ovf_o and zero_o in the same edge.
REQ-017 ovf_o SHALL equal the borrow into the MSB XOR the borrow out of the MSB.
REQ-018 Latency: with start sampled on edge 0, done_o SHALL be high exactly in the cycle after edge WIDTH (WIDTH cycles after acceptance).
REQ-019 busy_o SHALL be 1 exactly while the state is RUN.
REQ-020 done_o SHALL be 1 exactly while the state is DONE.
REQ-021 DONE with start_i=0 SHALL return to IDLE on the next edge.
REQ-022 DONE with start_i=1 SHALL accept the new operation (back-to-back) and still pulse done_o for one cycle only.
REQ-023 start_i while in RUN SHALL be ignored with no effect on the operation in progress.
REQ-024 a_i, b_i and bin_i changes after acceptance SHALL not affect the result.
REQ-025 d_o, bout_o, ovf_o and zero_o SHALL hold the last result until the next completion and SHALL not change during RUN.
REQ-026 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide, SHALL never wrap during an operation, and SHALL stop at WIDTH.

Reset
REQ-027 rstn_i=0 at an edge SHALL force IDLE and clear all outputs (d_o=0, bout_o=0, ovf_o=0, zero_o=0, busy_o=0, done_o=0), plus the shift registers, borrow register and counter.
REQ-028 Reset asserted mid-operation SHALL abort it with no done_o pulse.
REQ-029 The first start_i after rstn_i returns to 1 SHALL be accepted normally.
REQ-030 rstn_i SHALL take priority over start_i.

Verification (WIDTH=8)
REQ-031 a=0x05, b=0x03, bin=0 -> d=0x02, bout=0, ovf=0, zero=0; done_o 8 cycles after acceptance; busy_o high exactly 8 cycles.
REQ-032 a=0x03, b=0x05, bin=0 -> d=0xFE, bout=1, ovf=0, zero=0.
REQ-033 a=0x80, b=0x01, bin=0 -> d=0x7F, bout=0, ovf=1; a=0x10, b=0x0F, bin=1 -> d=0x00, zero=1, bout=0.
REQ-034 start_i pulsed at cycle 3 of RUN with other operands -> ignored, first result unchanged; start_i held in the DONE cycle -> second operation runs back-to-back, two single-cycle done_o pulses 9 cycles apart.
REQ-035 rstn_i=0 at cycle 4 of RUN -> all outputs 0 next cycle, no done_o; then a=0xFF, b=0xFF, bin=1 -> d=0xFF, bout=1, ovf=0.
